otter_fetch_stage: RTL and testbench
====================================

// Module: otter_fetch_stage
// PURPOSE
//  Instruction-fetch front end for the pipelined OTTER core. Owns the fetch PC and issues
//  in-order requests to instruction memory over a valid/ready request / valid response
//  interface. Buffers returned instructions and hands {pc, instr} to decode.
//  Discards wrong-path responses after a branch/jump redirect.
// PARAMETERS
//  XLEN       32     address/instruction width
//  RESET_VEC  32'h0  PC after reset; bits [1:0] must be 0
//  DEPTH      2      max requests in flight + buffered (power of 2, >=2)
// PORTS
//  CLK             in   1     core clock, all state on rising edge
//  RST             in   1     asynchronous reset, active-high
//  imem_req_valid  out  1     fetch request valid
//  imem_req_ready  in   1     memory accepts request this cycle
//  imem_addr       out  XLEN  fetch address (word aligned)
//  imem_rsp_valid  in   1     response valid; in order, >=1 cycle after acceptance
//  imem_rsp_data   in   XLEN  instruction word
//  redirect_valid  in   1     flush and restart at redirect_pc (from EX)
//  redirect_pc     in   XLEN  new PC; bits [1:0] ignored (forced 0)
//  id_ready        in   1     decode accepts head this cycle (0 = stall)
//  if_valid        out  1     {if_pc, if_instr} valid to decode
//  if_pc           out  XLEN  PC of presented instruction
//  if_instr        out  XLEN  presented instruction
//  if_pc_plus4     out  XLEN  if_pc + 4, mod 2^XLEN
// BEHAVIOUR
//  - Reset (async, immediate, no clock needed): fetch_pc=RESET_VEC; tag queue and output
//    buffer empty; imem_req_valid=0, if_valid=0, if_pc/if_instr/if_pc_plus4=0; imem_addr=RESET_VEC.
//  - imem_addr = fetch_pc at all times. req_valid = (inflight + buffered) < DEPTH && !redirect_valid.
//    First request may assert in the first cycle after RST deasserts.
//  - Accept (req_valid & req_ready): fetch_pc += 4 (wraps mod 2^XLEN); push {fetch_pc, live=1}
//    into in-flight tag queue (DEPTH entries).
//  - Response: pop tag queue head. If live=1, write {pc, data} into output FIFO
//    (DEPTH entries); if live=0, drop. Response with empty tag queue: drop, no state change
//    (simulation assertion fires).
//  - Output: if_valid = output FIFO non-empty; head drives if_pc/if_instr. Pop on
//    if_valid & id_ready. Response-to-if_valid latency is 1 cycle (registered FIFO write).
//    Throughput 1 instr/cycle with 1-cycle imem and id_ready=1.
//  - Outputs hold stable while if_valid & !id_ready.
//  - Redirect (highest priority): next cycle fetch_pc=redirect_pc&~3, output FIFO empty
//    (if_valid=0). All tag-queue entries get live=0, so stale responses are still popped but
//    dropped. No request is issued in the redirect cycle. A response or decode pop in the same
//    cycle is discarded. Back-to-back redirects: last one wins.
//  - Credit count covers both in-flight and buffered entries, so the output FIFO never
//    overflows. No response is lost while id_ready=0.
//  - RST mid-operation: all in-flight tags are forgotten. imem is reset in the same domain.
// TESTING
//  1 RST=1 for 200 ns, 1-cycle imem, id_ready=1 -> during reset all outputs 0; after release
//    if_pc = 0,4,8,... on consecutive cycles, if_instr = mem[pc].
//  2 id_ready=0 from cycle 3 -> req_valid drops after DEPTH outstanding+buffered; id_ready=1
//    at cycle 10 -> PCs resume in order, no gaps or duplicates.
//  3 imem latency 3, two requests in flight, redirect to 0x100 -> both stale responses dropped;
//    next if_pc = 0x100, then 0x104.
//  4 redirect 0x100 then 0x200 on consecutive cycles -> no 0x100-path instr ever valid;
//    first if_pc = 0x200.
//  5 RESET_VEC=32'hFFFF_FFFC -> imem_addr FFFF_FFFC then 0000_0000; if_pc_plus4 = 0 for first instr.
//  6 assert RST between clock edges mid-stream -> if_valid and imem_req_valid go 0 immediately;
//    after release, fetch restarts at RESET_VEC.

Source files
------------

// File: rtl/otter_fetch_stage.sv
// OTTER instruction fetch: credit-limited in-order imem requests, a tag queue that marks
// wrong-path responses for squashing, and a small output FIFO that feeds decode.
module otter_fetch_stage #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_VEC = '0,
    parameter int              DEPTH     = 2
) (
    input  logic            CLK,
    input  logic            RST,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            id_ready,
    output logic            if_valid,
    output logic [XLEN-1:0] if_pc,
    output logic [XLEN-1:0] if_instr,
    output logic [XLEN-1:0] if_pc_plus4
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;

    logic [XLEN-1:0]            fetch_pc_q, fetch_pc_d;
    logic [DEPTH-1:0][XLEN-1:0] tag_pc_q, tag_pc_d;
    logic [DEPTH-1:0]           tag_live_q, tag_live_d;
    logic [PW-1:0]              tag_wr_q, tag_wr_d, tag_rd_q, tag_rd_d;
    logic [CW-1:0]              tag_cnt_q, tag_cnt_d;
    logic [DEPTH-1:0][XLEN-1:0] buf_pc_q, buf_pc_d, buf_instr_q, buf_instr_d;
    logic [PW-1:0]              buf_wr_q, buf_wr_d, buf_rd_q, buf_rd_d;
    logic [CW-1:0]              buf_cnt_q, buf_cnt_d;

    logic        req_fire, rsp_pop, rsp_keep, id_pop;
    logic [CW:0] credit_used;

    always_comb begin
        if_valid       = (buf_cnt_q != '0);
        id_pop         = if_valid && id_ready;
        // a decode pop frees its slot in time for a request in the same cycle
        credit_used    = (CW+1)'(tag_cnt_q) + (CW+1)'(buf_cnt_q) - (CW+1)'(id_pop);
        imem_req_valid = !RST && !redirect_valid && (credit_used < (CW+1)'(DEPTH));
        imem_addr      = fetch_pc_q;
        req_fire       = imem_req_valid && imem_req_ready;
        rsp_pop        = imem_rsp_valid && (tag_cnt_q != '0);
        rsp_keep       = rsp_pop && tag_live_q[tag_rd_q] && !redirect_valid;
        if_pc          = '0;
        if_instr       = '0;
        if_pc_plus4    = '0;
        if (if_valid) begin
            if_pc       = buf_pc_q[buf_rd_q];
            if_instr    = buf_instr_q[buf_rd_q];
            if_pc_plus4 = buf_pc_q[buf_rd_q] + XLEN'(4);
        end
    end

    always_comb begin
        fetch_pc_d  = fetch_pc_q;
        tag_pc_d    = tag_pc_q;
        tag_live_d  = tag_live_q;
        tag_wr_d    = tag_wr_q;
        tag_rd_d    = tag_rd_q;
        buf_pc_d    = buf_pc_q;
        buf_instr_d = buf_instr_q;
        buf_wr_d    = buf_wr_q;
        buf_rd_d    = buf_rd_q;
        buf_cnt_d   = buf_cnt_q;

        if (redirect_valid) fetch_pc_d = redirect_pc & ~XLEN'(3);
        else if (req_fire)  fetch_pc_d = fetch_pc_q + XLEN'(4);

        if (req_fire) begin
            tag_pc_d[tag_wr_q]   = fetch_pc_q;
            tag_live_d[tag_wr_q] = 1'b1;
            tag_wr_d             = tag_wr_q + PW'(1);
        end
        if (rsp_pop) tag_rd_d = tag_rd_q + PW'(1);
        tag_cnt_d = tag_cnt_q + CW'(req_fire) - CW'(rsp_pop);
        // outstanding tags stay queued so their responses are still consumed, just not kept
        if (redirect_valid) tag_live_d = '0;

        if (redirect_valid) begin
            buf_rd_d  = buf_wr_q;
            buf_cnt_d = '0;
        end else begin
            if (rsp_keep) begin
                buf_pc_d[buf_wr_q]    = tag_pc_q[tag_rd_q];
                buf_instr_d[buf_wr_q] = imem_rsp_data;
                buf_wr_d              = buf_wr_q + PW'(1);
            end
            if (id_pop) buf_rd_d = buf_rd_q + PW'(1);
            buf_cnt_d = buf_cnt_q + CW'(rsp_keep) - CW'(id_pop);
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            fetch_pc_q  <= RESET_VEC;
            tag_pc_q    <= '0;
            tag_live_q  <= '0;
            tag_wr_q    <= '0;
            tag_rd_q    <= '0;
            tag_cnt_q   <= '0;
            buf_pc_q    <= '0;
            buf_instr_q <= '0;
            buf_wr_q    <= '0;
            buf_rd_q    <= '0;
            buf_cnt_q   <= '0;
        end else begin
            fetch_pc_q  <= fetch_pc_d;
            tag_pc_q    <= tag_pc_d;
            tag_live_q  <= tag_live_d;
            tag_wr_q    <= tag_wr_d;
            tag_rd_q    <= tag_rd_d;
            tag_cnt_q   <= tag_cnt_d;
            buf_pc_q    <= buf_pc_d;
            buf_instr_q <= buf_instr_d;
            buf_wr_q    <= buf_wr_d;
            buf_rd_q    <= buf_rd_d;
            buf_cnt_q   <= buf_cnt_d;
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge CLK) begin
        if (!RST && imem_rsp_valid)
            assert (tag_cnt_q != '0) else $error("imem response with no request outstanding");
    end
`endif
endmodule

// File: tb/tb_otter_fetch_stage.sv
// Directed bench for otter_fetch_stage: in-order imem model with programmable latency,
// table-driven stall/resume vectors, and hand sequences for redirect, wrap and async reset.
module tb_otter_fetch_stage;
    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        imem_req_valid, imem_req_ready, imem_rsp_valid, redirect_valid, id_ready;
    logic [31:0] imem_addr, imem_rsp_data, redirect_pc;
    logic        if_valid;
    logic [31:0] if_pc, if_instr, if_pc_plus4;

    logic        req_valid_w, rsp_valid_w, if_valid_w;
    logic [31:0] addr_w, rsp_data_w, if_pc_w, if_instr_w, if_plus4_w;

    always #5 CLK = ~CLK;

    otter_fetch_stage #(.XLEN(32), .RESET_VEC(32'h0), .DEPTH(2)) dut (
        .CLK(CLK), .RST(RST),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .id_ready(id_ready),
        .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr), .if_pc_plus4(if_pc_plus4)
    );

    otter_fetch_stage #(.XLEN(32), .RESET_VEC(32'hFFFF_FFFC), .DEPTH(2)) dut_w (
        .CLK(CLK), .RST(RST),
        .imem_req_valid(req_valid_w), .imem_req_ready(1'b1), .imem_addr(addr_w),
        .imem_rsp_valid(rsp_valid_w), .imem_rsp_data(rsp_data_w),
        .redirect_valid(1'b0), .redirect_pc(32'h0), .id_ready(1'b1),
        .if_valid(if_valid_w), .if_pc(if_pc_w), .if_instr(if_instr_w), .if_pc_plus4(if_plus4_w)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int lat = 1;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // instruction memory: requests accepted in cycle c answer in cycle c+lat, in order
    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;
    pend_t       pq[$];
    logic        acc_w = 1'b0;
    logic [31:0] acc_addr_w = 32'h0;

    always @(posedge CLK) cyc <= cyc + 1;

    always @(negedge CLK) begin
        if (!RST && imem_req_valid && imem_req_ready) pq.push_back('{imem_addr, cyc + lat});
        acc_w      <= !RST && req_valid_w;
        acc_addr_w <= addr_w;
    end

    initial begin
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        rsp_valid_w    = 1'b0;
        rsp_data_w     = 32'h0;
        forever begin
            @(posedge CLK);
            #1;
            rsp_valid_w = acc_w && !RST;
            rsp_data_w  = instr_of(acc_addr_w);
            if (RST) begin
                pq.delete();
                imem_rsp_valid = 1'b0;
            end else if (pq.size() > 0 && pq[0].due <= cyc) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = instr_of(pq[0].addr);
                void'(pq.pop_front());
            end else begin
                imem_rsp_valid = 1'b0;
            end
        end
    end

    task automatic next_cycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        @(posedge CLK);
        #2;
        RST = 1'b1;
        @(posedge CLK);
        @(posedge CLK);
        #3;
        RST = 1'b0;
    endtask

    typedef struct {
        logic        id_ready;
        logic        exp_valid;
        logic [31:0] exp_pc;
        logic        exp_req;
        logic [31:0] exp_addr;
    } vec_t;
    vec_t        vecs[14];
    logic [31:0] got[$];
    int          first_k;
    int          n_bad;

    initial begin
        imem_req_ready = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        id_ready       = 1'b1;

        vecs[0] = '{1'b1, 1'b0, 32'h0, 1'b1, 32'h0};
        vecs[1] = '{1'b1, 1'b0, 32'h0, 1'b1, 32'h4};
        vecs[2] = '{1'b1, 1'b1, 32'h0, 1'b1, 32'h8};
        for (int i = 3; i < 10; i++) vecs[i] = '{1'b0, 1'b1, 32'h4, 1'b0, 32'hC};
        vecs[10] = '{1'b1, 1'b1, 32'h4,  1'b1, 32'hC};
        vecs[11] = '{1'b1, 1'b1, 32'h8,  1'b1, 32'h10};
        vecs[12] = '{1'b1, 1'b1, 32'hC,  1'b1, 32'h14};
        vecs[13] = '{1'b1, 1'b1, 32'h10, 1'b1, 32'h18};

        // reset state
        #100;
        chk("rst_req_valid", 32'(imem_req_valid), 32'h0);
        chk("rst_if_valid", 32'(if_valid), 32'h0);
        chk("rst_if_pc", if_pc, 32'h0);
        chk("rst_if_instr", if_instr, 32'h0);
        chk("rst_if_pc_plus4", if_pc_plus4, 32'h0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_addr_w", addr_w, 32'hFFFF_FFFC);
        chk("rst_req_valid_w", 32'(req_valid_w), 32'h0);
        #97;
        RST = 1'b0;

        // stream, stall from cycle 3, resume at cycle 10; wrap instance checked alongside
        for (int i = 0; i < 14; i++) begin
            id_ready = vecs[i].id_ready;
            @(negedge CLK);
            chk($sformatf("t1_if_valid[%0d]", i), 32'(if_valid), 32'(vecs[i].exp_valid));
            chk($sformatf("t1_req_valid[%0d]", i), 32'(imem_req_valid), 32'(vecs[i].exp_req));
            chk($sformatf("t1_addr[%0d]", i), imem_addr, vecs[i].exp_addr);
            if (vecs[i].exp_valid) begin
                chk($sformatf("t1_if_pc[%0d]", i), if_pc, vecs[i].exp_pc);
                chk($sformatf("t1_if_instr[%0d]", i), if_instr, instr_of(vecs[i].exp_pc));
                chk($sformatf("t1_pc4[%0d]", i), if_pc_plus4, vecs[i].exp_pc + 32'h4);
            end
            if (i == 0) begin
                chk("t5_addr0", addr_w, 32'hFFFF_FFFC);
                chk("t5_req0", 32'(req_valid_w), 32'h1);
            end
            if (i == 1) chk("t5_addr1", addr_w, 32'h0);
            if (i == 2) begin
                chk("t5_valid", 32'(if_valid_w), 32'h1);
                chk("t5_pc", if_pc_w, 32'hFFFF_FFFC);
                chk("t5_pc4", if_plus4_w, 32'h0);
                chk("t5_instr", if_instr_w, instr_of(32'hFFFF_FFFC));
            end
            if (i == 3) begin
                chk("t5_pc_next", if_pc_w, 32'h0);
                chk("t5_pc4_next", if_plus4_w, 32'h4);
            end
            next_cycle();
        end
        id_ready = 1'b1;

        // latency 3, two in flight, redirect to 0x100
        lat = 3;
        do_reset();
        @(negedge CLK);
        chk("t3_addr0", imem_addr, 32'h0);
        chk("t3_req0", 32'(imem_req_valid), 32'h1);
        next_cycle();
        @(negedge CLK);
        chk("t3_addr1", imem_addr, 32'h4);
        next_cycle();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        @(negedge CLK);
        chk("t3_req_redir", 32'(imem_req_valid), 32'h0);
        next_cycle();
        redirect_valid = 1'b0;
        got.delete();
        first_k = -1;
        for (int k = 0; k < 16; k++) begin
            @(negedge CLK);
            if (if_valid) begin
                if (first_k < 0) first_k = k;
                got.push_back(if_pc);
                chk($sformatf("t3_instr[%0d]", k), if_instr, instr_of(if_pc));
            end
            next_cycle();
        end
        chk("t3_seen_two", 32'(got.size() >= 2), 32'h1);
        if (got.size() >= 2) begin
            chk("t3_first_pc", got[0], 32'h100);
            chk("t3_second_pc", got[1], 32'h104);
        end
        chk("t3_first_cycle", 32'(first_k), 32'h5);

        // back-to-back redirects, last one wins, low bits forced to zero
        lat = 1;
        do_reset();
        @(negedge CLK);
        chk("t4_addr0", imem_addr, 32'h0);
        next_cycle();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        @(negedge CLK);
        chk("t4_req_redir1", 32'(imem_req_valid), 32'h0);
        next_cycle();
        redirect_pc = 32'h203;
        @(negedge CLK);
        chk("t4_req_redir2", 32'(imem_req_valid), 32'h0);
        chk("t4_valid_redir2", 32'(if_valid), 32'h0);
        chk("t4_addr_redir2", imem_addr, 32'h100);
        next_cycle();
        redirect_valid = 1'b0;
        @(negedge CLK);
        chk("t4_addr_new", imem_addr, 32'h200);
        chk("t4_req_new", 32'(imem_req_valid), 32'h1);
        next_cycle();
        got.delete();
        first_k = -1;
        n_bad = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge CLK);
            if (if_valid) begin
                if (first_k < 0) first_k = k;
                got.push_back(if_pc);
                if (if_pc < 32'h200) n_bad++;
            end
            next_cycle();
        end
        chk("t4_stale_seen", 32'(n_bad), 32'h0);
        chk("t4_seen_two", 32'(got.size() >= 2), 32'h1);
        if (got.size() >= 2) begin
            chk("t4_first_pc", got[0], 32'h200);
            chk("t4_second_pc", got[1], 32'h204);
        end
        chk("t4_first_cycle", 32'(first_k), 32'h1);

        // asynchronous reset between clock edges mid-stream
        @(negedge CLK);
        chk("t6_pre_valid", 32'(if_valid), 32'h1);
        #2;
        RST = 1'b1;
        #1;
        chk("t6_if_valid", 32'(if_valid), 32'h0);
        chk("t6_req_valid", 32'(imem_req_valid), 32'h0);
        chk("t6_addr", imem_addr, 32'h0);
        chk("t6_if_pc", if_pc, 32'h0);
        chk("t6_if_instr", if_instr, 32'h0);
        chk("t6_pc4", if_pc_plus4, 32'h0);
        @(posedge CLK);
        #3;
        RST = 1'b0;
        @(negedge CLK);
        chk("t6_addr0", imem_addr, 32'h0);
        chk("t6_req0", 32'(imem_req_valid), 32'h1);
        next_cycle();
        @(negedge CLK);
        chk("t6_addr1", imem_addr, 32'h4);
        next_cycle();
        @(negedge CLK);
        chk("t6_valid2", 32'(if_valid), 32'h1);
        chk("t6_pc2", if_pc, 32'h0);
        chk("t6_instr2", if_instr, instr_of(32'h0));
        next_cycle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
